// File: rtl/period_meter.sv
// ============================================================================
//  Module   : period_meter
//  Purpose  : Measures the spacing in clk cycles between rising edges of a
//             strobe and reports it with a one-cycle valid pulse.
//  Options  : PERIOD_FILTER_EN - accept a measurement only when it repeats.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module period_meter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             strobe_in,
   output logic [WIDTH-1:0] period,
   output logic             valid,
   output logic             overflow
);

   localparam logic [WIDTH-1:0] CNT_MAX = '1;
   localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_MEASURE = 2'd1,
      S_OVF     = 2'd2
   } state_t;

   state_t           state_q;
   logic             prev_q;
   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] period_q;
   logic             valid_q;
   logic             overflow_q;
`ifdef PERIOD_FILTER_EN
   logic [WIDTH-1:0] cand_q;
   logic             cand_vld_q;
`endif

   logic rise;
   assign rise = strobe_in & ~prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         prev_q     <= 1'b0;
         cnt_q      <= '0;
         period_q   <= '0;
         valid_q    <= 1'b0;
         overflow_q <= 1'b0;
`ifdef PERIOD_FILTER_EN
         cand_q     <= '0;
         cand_vld_q <= 1'b0;
`endif
      end else begin
         prev_q  <= strobe_in;
         valid_q <= 1'b0;
         if (!en) begin
            // Disarm; period and overflow keep their last values.
            state_q <= S_IDLE;
            cnt_q   <= '0;
`ifdef PERIOD_FILTER_EN
            cand_vld_q <= 1'b0;
`endif
         end else begin
            case (state_q)
               S_IDLE, S_OVF: begin
                  if (rise) begin
                     cnt_q   <= CNT_ONE;
                     state_q <= S_MEASURE;
`ifdef PERIOD_FILTER_EN
                     cand_vld_q <= 1'b0;
`endif
                  end
               end
               S_MEASURE: begin
                  if (rise) begin
                     // An edge on the saturating cycle still counts as a measurement.
                     cnt_q <= CNT_ONE;
`ifdef PERIOD_FILTER_EN
                     if (cand_vld_q && (cnt_q == cand_q)) begin
                        period_q   <= cnt_q;
                        valid_q    <= 1'b1;
                        overflow_q <= 1'b0;
                     end else begin
                        cand_q     <= cnt_q;
                        cand_vld_q <= 1'b1;
                     end
`else
                     period_q   <= cnt_q;
                     valid_q    <= 1'b1;
                     overflow_q <= 1'b0;
`endif
                  end else if (cnt_q == CNT_MAX) begin
                     overflow_q <= 1'b1;
                     state_q    <= S_OVF;
                  end else begin
                     cnt_q <= cnt_q + CNT_ONE;
                  end
               end
               default: begin
                  state_q <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign period   = period_q;
   assign valid    = valid_q;
   assign overflow = overflow_q;

endmodule

`default_nettype wire
